// File: rtl/bus_interface_unit_pkg.sv
// Shared encodings for the bus interface unit: FSM states, write-enable
// polarity and data-pin output-enable patterns.
package bus_interface_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    DATA    = 2'd3
  } bus_state_e;

  localparam logic       WE_WRITE = 1'b1;
  localparam logic       WE_READ  = 1'b0;

  localparam logic [7:0] OE_ALL   = 8'hFF;
  localparam logic [7:0] OE_NONE  = 8'h00;

  localparam int         WAIT_W   = 4;

endpackage

// File: rtl/bus_interface_unit.sv
// Sequences one 16-bit core transaction onto the 8-bit multiplexed pins:
// address high byte, address low byte, then a data phase gated by wait states and RDY.
module bus_interface_unit
  import bus_interface_unit_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       clk_output,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [15:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rdata,
  input  logic       rdy,
  output logic [7:0] bus_addr,
  output logic       bus_hi,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_data_out,
  output logic [7:0] bus_data_oe
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  bus_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              we_q;
  logic [7:0]        addr_lo_q;
  logic [7:0]        wdata_q;

  always_ff @(posedge clk_output) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      we_q         <= WE_READ;
      addr_lo_q    <= 8'h00;
      wdata_q      <= 8'h00;
      busy         <= 1'b0;
      ack          <= 1'b0;
      rdata        <= 8'h00;
      bus_addr     <= 8'h00;
      bus_hi       <= 1'b0;
      bus_data_out <= 8'h00;
      bus_data_oe  <= OE_NONE;
    end else begin
      ack <= 1'b0;
      case (state)
        // The ack term keeps a core still holding req from re-issuing the same transaction
        IDLE: begin
          if (req && !ack) begin
            we_q      <= we;
            addr_lo_q <= addr[7:0];
            wdata_q   <= wdata;
            busy      <= 1'b1;
            bus_addr  <= addr[15:8];
            bus_hi    <= 1'b1;
            state     <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          bus_addr <= addr_lo_q;
          bus_hi   <= 1'b0;
          state    <= ADDR_LO;
        end
        ADDR_LO: begin
          wait_cnt <= WAIT_LOAD;
          if (we_q == WE_WRITE) begin
            bus_data_out <= wdata_q;
            bus_data_oe  <= OE_ALL;
          end
          state <= DATA;
        end
        // rdy only matters once the wait counter has drained
        DATA: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (rdy) begin
            if (we_q == WE_READ) rdata <= bus_data_in;
            bus_data_oe <= OE_NONE;
            ack         <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Scoreboarded bench for bus_interface_unit: one instance with no wait states,
// one with two wait states.
module tb_bus_interface_unit;

  logic        clk_output = 1'b0;
  logic        rst_n;
  logic        req, req2, we, rdy;
  logic [15:0] addr;
  logic [7:0]  wdata, bus_data_in;

  logic        busy_0, ack_0, hi_0;
  logic [7:0]  rdata_0, baddr_0, dout_0, oe_0;
  logic        busy_2, ack_2, hi_2;
  logic [7:0]  rdata_2, baddr_2, dout_2, oe_2;

  typedef struct {
    logic       w;
    logic [7:0] d;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk_output = ~clk_output;

  bus_interface_unit #(.WAIT_CYCLES(0)) dut0 (
    .clk_output(clk_output), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .busy(busy_0), .ack(ack_0), .rdata(rdata_0), .rdy(rdy),
    .bus_addr(baddr_0), .bus_hi(hi_0), .bus_data_in(bus_data_in),
    .bus_data_out(dout_0), .bus_data_oe(oe_0)
  );

  bus_interface_unit #(.WAIT_CYCLES(2)) dut2 (
    .clk_output(clk_output), .rst_n(rst_n), .req(req2), .we(we), .addr(addr),
    .wdata(wdata), .busy(busy_2), .ack(ack_2), .rdata(rdata_2), .rdy(rdy),
    .bus_addr(baddr_2), .bus_hi(hi_2), .bus_data_in(bus_data_in),
    .bus_data_out(dout_2), .bus_data_oe(oe_2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_output);
    #1;
  endtask

  // Completion scoreboard for the zero-wait instance
  always @(posedge clk_output) begin
    #1;
    if (ack_0) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (!e.w) check("sb_rdata", rdata_0, e.d);
        else      check("sb_wr_oe_at_ack", oe_0, 8'h00);
        check("sb_busy_at_ack", busy_0, 0);
      end
    end
  end

  task automatic txn0(input logic w, input logic [15:0] a, input logic [7:0] wd,
                      input logic [7:0] din, input int rdy_low, input int exp_lat,
                      input string tag);
    int  k;
    bit  done;
    sb.push_back('{w: w, d: din});
    we = w; addr = a; wdata = wd; bus_data_in = din; rdy = 1'b1; req = 1'b1;
    step();
    check({tag, "_busy"}, busy_0, 1);
    check({tag, "_ahi"}, baddr_0, a[15:8]);
    check({tag, "_hi1"}, hi_0, 1);
    req = 1'b0; addr = ~a; wdata = ~wd; we = ~w;
    step();
    check({tag, "_alo"}, baddr_0, a[7:0]);
    check({tag, "_hi0"}, hi_0, 0);
    check({tag, "_oe_addr"}, oe_0, 8'h00);
    step();
    check({tag, "_oe_data"}, oe_0, w ? 8'hFF : 8'h00);
    if (w) check({tag, "_dout"}, dout_0, wd);
    k = 2;
    done = 0;
    while (!done && k < 40) begin
      k++;
      rdy = (k - 3 >= rdy_low);
      bus_data_in = rdy ? din : (din ^ 8'(k));
      step();
      if (ack_0) done = 1;
      else check({tag, "_oe_hold"}, oe_0, w ? 8'hFF : 8'h00);
    end
    check({tag, "_lat"}, k, exp_lat);
    rdy = 1'b1;
    step();
    check({tag, "_ack_clr"}, ack_0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  done;
    rst_n = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0; addr = 16'h0;
    wdata = 8'h0; rdy = 1'b1; bus_data_in = 8'h0;
    step();
    step();
    check("rst_busy", busy_0, 0);
    check("rst_ack", ack_0, 0);
    check("rst_rdata", rdata_0, 8'h00);
    check("rst_baddr", baddr_0, 8'h00);
    check("rst_hi", hi_0, 0);
    check("rst_oe", oe_0, 8'h00);
    check("rst_dout", dout_0, 8'h00);
    rst_n = 1'b1;
    step();

    txn0(1'b0, 16'h12AB, 8'h00, 8'h5A, 0, 3, "rd");
    txn0(1'b1, 16'hFFFE, 8'hC3, 8'h00, 0, 3, "wr");
    txn0(1'b0, 16'h0200, 8'h00, 8'h3C, 4, 7, "rdy_lo");
    check("rdy_lo_hold_bus", baddr_0, 8'h00);

    // Two wait states: rdy toggling during countdown must not matter
    we = 1'b0; addr = 16'h3456; bus_data_in = 8'h77; req2 = 1'b1; rdy = 1'b1;
    step();
    check("w2_busy", busy_2, 1);
    check("w2_ahi", baddr_2, 8'h34);
    req2 = 1'b0;
    k = 0;
    done = 0;
    while (!done && k < 40) begin
      k++;
      rdy = (k >= 5) ? 1'b1 : k[0];
      step();
      if (ack_2) done = 1;
    end
    check("w2_lat", k, 5);
    check("w2_rdata", rdata_2, 8'h77);
    check("w2_dut0_idle", busy_0, 0);
    rdy = 1'b1;
    step();

    // Back-to-back with req held high
    sb.push_back('{w: 1'b0, d: 8'h11});
    sb.push_back('{w: 1'b0, d: 8'h22});
    we = 1'b0; addr = 16'h0001; bus_data_in = 8'h11; req = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      case (e)
        0: begin
          check("b2b_acc1", busy_0, 1);
          check("b2b_acc1_addr", baddr_0, 8'h00);
          addr = 16'h0002;
        end
        1: check("b2b_lo1", baddr_0, 8'h01);
        3: begin
          check("b2b_ack1", ack_0, 1);
          bus_data_in = 8'h22;
        end
        4: check("b2b_no_double", busy_0, 0);
        5: begin
          check("b2b_acc2", busy_0, 1);
          check("b2b_acc2_hi", hi_0, 1);
          addr = 16'hBEEF;
        end
        6: check("b2b_lo2", baddr_0, 8'h02);
        8: begin
          check("b2b_ack2", ack_0, 1);
          req = 1'b0;
        end
        10: check("b2b_idle", busy_0, 0);
        default: ;
      endcase
    end

    // Reset in the middle of a write data phase
    we = 1'b1; addr = 16'h4321; wdata = 8'h99; rdy = 1'b0; req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    check("rstw_oe_on", oe_0, 8'hFF);
    step();
    rst_n = 1'b0;
    step();
    check("rstw_oe", oe_0, 8'h00);
    check("rstw_busy", busy_0, 0);
    check("rstw_ack", ack_0, 0);
    check("rstw_baddr", baddr_0, 8'h00);
    check("rstw_hi", hi_0, 0);
    check("rstw_dout", dout_0, 8'h00);
    check("rstw_rdata", rdata_0, 8'h00);
    rst_n = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rstw_no_ack", ack_0, 0);
    end

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
